fb_mem_arbiter: RTL and testbench
=================================

// Module: fb_mem_arbiter
// PURPOSE
//  Shares one 16-bit framebuffer memory port (front end of the SDRAM controller) between two requesters.
//  Requester 1: VGA scan-out line fetcher. Read bursts, deadline-critical.
//  Requester 2: Gouraud rasterizer pixel writer. Single-word writes.
//  Sits inside core, between the renderer/VGA logic and the SDRAM controller.
// PARAMETERS
//  ADR_W       22  word-address width of the memory port
//  LEN_W        9  width of disp_len (max burst 2^LEN_W-1 words)
//  DRAW_QUOTA   4  consecutive draw writes allowed before yielding to a pending display burst
// PORTS
//  m_clock     in   1      system clock (50 MHz)
//  p_reset_n   in   1      synchronous reset, active-low
//  disp_req    in   1      display burst request; held high until disp_done
//  disp_adr    in   ADR_W  burst start word address; sampled at grant
//  disp_len    in   LEN_W  burst length in words; sampled at grant
//  disp_rvalid out  1      one read word valid on disp_rdata
//  disp_rdata  out  16     read data
//  disp_done   out  1      1-cycle pulse after the last word of the burst
//  draw_req    in   1      draw write request; adr/data held stable until draw_ack
//  draw_adr    in   ADR_W  write word address
//  draw_data   in   16     write data
//  draw_ack    out  1      1-cycle pulse: write accepted by memory
//  mem_req     out  1      memory command valid
//  mem_we      out  1      1 = write, 0 = read
//  mem_adr     out  ADR_W  command address
//  mem_wdata   out  16     write data
//  mem_ack     in   1      command accepted this cycle
//  mem_rvalid  in   1      read data valid (in order, arbitrary latency >= 1)
//  mem_rdata   in   16     read data
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. Counters 0.
//  Reset mid-burst aborts the burst. mem_rvalid is ignored until the next DISP grant.
//  FSM states:
//   IDLE -> DISP if disp_req; else -> DRAW if draw_req. Display wins ties.
//   DISP: mem_req=1, mem_we=0, mem_adr=base+issued.
//    Each mem_ack increments issued. mem_req drops the cycle after issued==len.
//    Each mem_rvalid: disp_rvalid=1 and disp_rdata=mem_rdata, same cycle (combinational pass-through).
//    When received==len: disp_done pulses next cycle, then -> IDLE.
//   DRAW: mem_req=1, mem_we=1, mem_adr/mem_wdata = draw_adr/draw_data.
//    On mem_ack: draw_ack pulses the same cycle and quota_cnt increments.
//    After each ack: if disp_req && quota_cnt==DRAW_QUOTA -> IDLE (quota cleared);
//    else if draw_req still high next cycle, stay; else -> IDLE.
//    quota_cnt clears on entry to DISP.
//  Grant latency: request sampled in IDLE -> mem_req high on the next cycle.
//  Addressing: address increments modulo 2^ADR_W (wraps at top of memory).
//  disp_len==0: no memory access; disp_done pulses 2 cycles after grant.
//  mem_ack and mem_rvalid may occur in the same cycle; both are counted.
//  mem_rvalid outside DISP is discarded.
//  mem_req deasserts only when a command is accepted or the burst is fully issued; never mid-handshake.
//  At most one requester is granted at any time. Memory port outputs change only in IDLE or on mem_ack.
// CONFIGURATION
//  FB_ARB_STATS_EN defined: adds outputs stat_disp_words[15:0], stat_draw_words[15:0], stat_stall[15:0].
//   stat_disp_words / stat_draw_words: count accepted words per requester.
//   stat_stall: counts cycles with draw_req high while not in DRAW.
//   All saturate at 16'hFFFF and clear on reset. Intended for the HEX display.
//  FB_ARB_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. disp_req, adr=0x100, len=4, mem_ack every cycle, rvalid latency 3
//     -> mem_adr 0x100..0x103, 4 disp_rvalid, disp_done 1 cycle after 4th rvalid.
//  2. disp_req and draw_req rise in the same cycle
//     -> display burst first; draw_ack only after disp_done.
//  3. draw_req continuously high, DRAW_QUOTA=4, disp_req rises after 1st write
//     -> exactly 4 draw_acks, then display burst, then draws resume.
//  4. disp_adr=0x3FFFFE, len=4 -> mem_adr 3FFFFE, 3FFFFF, 000000, 000001.
//  5. disp_len=0 -> no mem_req, disp_done pulse 2 cycles after grant.
//  6. p_reset_n low after 2 of 8 reads issued
//     -> all outputs 0 next cycle; late mem_rvalid produces no disp_rvalid; next request is served normally.

Source files
------------

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Shares one 16-bit framebuffer memory port (SDRAM controller front end)
//   between the VGA line fetcher (read bursts, deadline-critical) and the
//   Gouraud rasterizer pixel writer (single-word writes).
//
// Ports
//   m_clock, p_reset_n              clock, synchronous active-low reset
//   disp_req/adr/len                display burst request (adr/len sampled at grant)
//   disp_rvalid/rdata/done          read data pass-through, end-of-burst pulse
//   draw_req/adr/data, draw_ack     single-word write request and accept pulse
//   mem_req/we/adr/wdata, mem_ack   memory command channel
//   mem_rvalid/rdata                in-order read return channel
//
// Build option
//   FB_ARB_STATS_EN : adds stat_disp_words, stat_draw_words, stat_stall
//                     saturating 16-bit counters (for the HEX display).
module fb_mem_arbiter #(
  parameter int ADR_W      = 22,
  parameter int LEN_W      = 9,
  parameter int DRAW_QUOTA = 4
) (
  input  logic             m_clock,
  input  logic             p_reset_n,
  input  logic             disp_req,
  input  logic [ADR_W-1:0] disp_adr,
  input  logic [LEN_W-1:0] disp_len,
  output logic             disp_rvalid,
  output logic [15:0]      disp_rdata,
  output logic             disp_done,
  input  logic             draw_req,
  input  logic [ADR_W-1:0] draw_adr,
  input  logic [15:0]      draw_data,
  output logic             draw_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADR_W-1:0] mem_adr,
  output logic [15:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic             mem_rvalid,
  input  logic [15:0]      mem_rdata
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]      stat_disp_words,
  output logic [15:0]      stat_draw_words,
  output logic [15:0]      stat_stall
`endif
);

  localparam int QW = $clog2(DRAW_QUOTA + 1);
  localparam logic [QW-1:0]    QUOTA_MAX = QW'(DRAW_QUOTA);
  localparam logic [QW-1:0]    QUOTA_ONE = QW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  // ST_DONE holds the done pulse so the display requester can drop disp_req
  // before IDLE samples it again.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ADR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] received_q, received_d;
  logic [QW-1:0]    quota_q, quota_d;
  logic [QW-1:0]    quota_inc;
  logic             rx_eff;

  // Next-state, counters and all port outputs
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    received_d  = received_q;
    quota_d     = quota_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_adr     = {ADR_W{1'b0}};
    mem_wdata   = 16'h0000;
    disp_rvalid = 1'b0;
    disp_rdata  = 16'h0000;
    disp_done   = 1'b0;
    draw_ack    = 1'b0;
    // A return beat beyond the burst length must not push received past len.
    rx_eff      = mem_rvalid && (received_q != len_q);
    quota_inc   = (quota_q == QUOTA_MAX) ? quota_q : (quota_q + QUOTA_ONE);

    case (state_q)
      ST_IDLE: begin
        if (disp_req) begin
          state_d    = ST_DISP;
          base_d     = disp_adr;
          len_d      = disp_len;
          issued_d   = {LEN_W{1'b0}};
          received_d = {LEN_W{1'b0}};
          quota_d    = {QW{1'b0}};
        end else if (draw_req) begin
          state_d = ST_DRAW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DISP: begin
        mem_req     = (issued_q != len_q);
        mem_adr     = base_q + ADR_W'(issued_q);
        disp_rvalid = mem_rvalid;
        disp_rdata  = mem_rvalid ? mem_rdata : 16'h0000;
        if (mem_req && mem_ack) begin
          issued_d = issued_q + LEN_ONE;
        end else begin
          issued_d = issued_q;
        end
        if (rx_eff) begin
          received_d = received_q + LEN_ONE;
        end else begin
          received_d = received_q;
        end
        // Counting this cycle's beat lets done follow the last beat by one cycle.
        if ((received_q + LEN_W'(rx_eff)) == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DISP;
        end
      end
      ST_DRAW: begin
        mem_req   = draw_req;
        mem_we    = 1'b1;
        mem_adr   = draw_adr;
        mem_wdata = draw_data;
        if (!draw_req) begin
          state_d = ST_IDLE;
        end else if (mem_ack) begin
          draw_ack = 1'b1;
          if (disp_req && (quota_inc == QUOTA_MAX)) begin
            state_d = ST_IDLE;
            quota_d = {QW{1'b0}};
          end else begin
            state_d = ST_DRAW;
            quota_d = quota_inc;
          end
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_DONE: begin
        disp_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge m_clock) begin
    if (!p_reset_n) begin
      state_q    <= ST_IDLE;
      base_q     <= {ADR_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      issued_q   <= {LEN_W{1'b0}};
      received_q <= {LEN_W{1'b0}};
      quota_q    <= {QW{1'b0}};
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      quota_q    <= quota_d;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] stat_disp_q, stat_disp_d;
  logic [15:0] stat_draw_q, stat_draw_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? (v + 16'd1) : v;
  endfunction

  // Statistics next values
  always_comb begin
    stat_disp_d  = sat_inc(stat_disp_q, (state_q == ST_DISP) && mem_req && mem_ack);
    stat_draw_d  = sat_inc(stat_draw_q, (state_q == ST_DRAW) && mem_req && mem_ack);
    stat_stall_d = sat_inc(stat_stall_q, draw_req && (state_q != ST_DRAW));
  end

  // Statistics registers
  always_ff @(posedge m_clock) begin
    if (!p_reset_n) begin
      stat_disp_q  <= 16'h0000;
      stat_draw_q  <= 16'h0000;
      stat_stall_q <= 16'h0000;
    end else begin
      stat_disp_q  <= stat_disp_d;
      stat_draw_q  <= stat_draw_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_disp_words = stat_disp_q;
  assign stat_draw_words = stat_draw_q;
  assign stat_stall      = stat_stall_q;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter: table-driven display bursts plus
// hand-written tie, quota and mid-burst reset sequences. The memory model
// accepts a command whenever ack_en is set and returns read data with a
// fixed latency of 3 cycles.
module tb_fb_mem_arbiter;

  localparam int ADR_W = 22;
  localparam int LEN_W = 9;

  logic             clk = 1'b0;
  logic             p_reset_n;
  logic             disp_req;
  logic [ADR_W-1:0] disp_adr;
  logic [LEN_W-1:0] disp_len;
  logic             disp_rvalid;
  logic [15:0]      disp_rdata;
  logic             disp_done;
  logic             draw_req;
  logic [ADR_W-1:0] draw_adr;
  logic [15:0]      draw_data;
  logic             draw_ack;
  logic             mem_req;
  logic             mem_we;
  logic [ADR_W-1:0] mem_adr;
  logic [15:0]      mem_wdata;
  logic             mem_ack;
  logic             mem_rvalid;
  logic [15:0]      mem_rdata;
  logic             ack_en;
`ifdef FB_ARB_STATS_EN
  logic [15:0]      stat_disp_words;
  logic [15:0]      stat_draw_words;
  logic [15:0]      stat_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_mem_arbiter #(.ADR_W(ADR_W), .LEN_W(LEN_W), .DRAW_QUOTA(4)) dut (
    .m_clock     (clk),
    .p_reset_n   (p_reset_n),
    .disp_req    (disp_req),
    .disp_adr    (disp_adr),
    .disp_len    (disp_len),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .disp_done   (disp_done),
    .draw_req    (draw_req),
    .draw_adr    (draw_adr),
    .draw_data   (draw_data),
    .draw_ack    (draw_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_adr     (mem_adr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
`ifdef FB_ARB_STATS_EN
    ,
    .stat_disp_words (stat_disp_words),
    .stat_draw_words (stat_draw_words),
    .stat_stall      (stat_stall)
`endif
  );

  function automatic logic [15:0] pat(input logic [ADR_W-1:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // Memory model: immediate accept, read data 3 cycles after accept.
  assign mem_ack = mem_req & ack_en;
  logic [2:0]  pv_q = 3'b000;
  logic [15:0] pd0_q = 16'h0000;
  logic [15:0] pd1_q = 16'h0000;
  logic [15:0] pd2_q = 16'h0000;
  always @(posedge clk) begin
    pv_q  <= {pv_q[1:0], (mem_req & mem_ack & ~mem_we)};
    pd0_q <= pat(mem_adr);
    pd1_q <= pd0_q;
    pd2_q <= pd1_q;
  end
  assign mem_rvalid = pv_q[2];
  assign mem_rdata  = pd2_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mem_req, mem_we, mem_adr, mem_wdata, disp_rvalid, disp_rdata,
                disp_done, draw_ack});
  endfunction

  // One display burst from IDLE; cycle 0 is the cycle IDLE sees the request.
  task automatic run_disp(input logic [ADR_W-1:0] adr, input logic [LEN_W-1:0] len,
                          input logic [ADR_W-1:0] last, input string tag);
    int n_cmd, n_rv, n_done, last_rv, done_cyc, first_req, exp_first, exp_done;
    logic [ADR_W-1:0] e_adr, r_adr, l_adr;
    n_cmd = 0; n_rv = 0; n_done = 0; last_rv = -1; done_cyc = -1; first_req = -1;
    e_adr = adr; r_adr = adr; l_adr = 22'h000000;
    @(posedge clk); #1;
    disp_adr = adr;
    disp_len = len;
    disp_req = 1'b1;
    for (int c = 0; c < int'(len) + 20 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_req && first_req < 0) first_req = c;
      if (mem_req && mem_ack) begin
        chk({tag, "_cmd"}, 64'({mem_we, mem_adr}), 64'({1'b0, e_adr}));
        l_adr = mem_adr;
        e_adr = e_adr + 22'd1;
        n_cmd++;
      end
      if (disp_rvalid) begin
        chk({tag, "_rdata"}, 64'(disp_rdata), 64'(pat(r_adr)));
        r_adr = r_adr + 22'd1;
        n_rv++;
        last_rv = c;
      end
      if (disp_done) begin
        n_done++;
        done_cyc = c;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0) disp_req = 1'b0;
    end
    disp_req = 1'b0;
    @(negedge clk);
    chk({tag, "_done_width"}, 64'(disp_done), 64'(1'b0));
    exp_first = (len == 9'd0) ? -1 : 1;
    exp_done  = (len == 9'd0) ? 2 : last_rv + 1;
    chk({tag, "_first_req"}, 64'(first_req), 64'(exp_first));
    chk({tag, "_n_cmd"}, 64'(n_cmd), 64'(len));
    chk({tag, "_n_rvalid"}, 64'(n_rv), 64'(len));
    chk({tag, "_n_done"}, 64'(n_done), 64'(1));
    chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
    chk({tag, "_last_adr"}, 64'(l_adr), 64'(last));
  endtask

  typedef struct {
    logic [ADR_W-1:0] adr;
    logic [LEN_W-1:0] len;
    logic [ADR_W-1:0] last;
  } vec_t;

  vec_t vecs [5];

  int  pre, acks, reads, resumed, done_c, ack_c, n, late;
  logic read_seen, got_ack, first_seen;

  initial begin
    vecs[0] = '{adr: 22'h000100, len: 9'd4, last: 22'h000103};
    vecs[1] = '{adr: 22'h3FFFFE, len: 9'd4, last: 22'h000001};
    vecs[2] = '{adr: 22'h000777, len: 9'd0, last: 22'h000000};
    vecs[3] = '{adr: 22'h0002A5, len: 9'd1, last: 22'h0002A5};
    vecs[4] = '{adr: 22'h012345, len: 9'd9, last: 22'h01234D};

    p_reset_n = 1'b0; disp_req = 1'b0; disp_adr = 22'h0; disp_len = 9'd0;
    draw_req = 1'b0; draw_adr = 22'h0; draw_data = 16'h0; ack_en = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    @(posedge clk); #1;
    p_reset_n = 1'b1;

    // Display bursts: basic, address wrap, zero length, single, longer
    for (int i = 0; i < 5; i++) begin
      run_disp(vecs[i].adr, vecs[i].len, vecs[i].last, $sformatf("vec%0d", i));
    end

    // Quota: continuous draws, display request after the first write
    @(posedge clk); #1;
    draw_adr = 22'h000500; draw_data = 16'h1000; draw_req = 1'b1;
    pre = 0; acks = 0; reads = 0; resumed = 0; done_c = -1; read_seen = 1'b0;
    for (int c = 0; c < 80 && resumed < 2; c++) begin
      @(negedge clk);
      got_ack = draw_ack;
      if (draw_ack) begin
        chk("quota_wr_cmd", 64'({mem_we, mem_adr, mem_wdata}),
            64'({1'b1, 22'h000500 + 22'(acks), 16'h1000 + 16'(acks)}));
        acks++;
        if (!read_seen) pre++;
        if (done_c >= 0) resumed++;
      end
      if (mem_req && mem_ack && !mem_we) begin
        read_seen = 1'b1;
        reads++;
      end
      if (disp_done) done_c = c;
      @(posedge clk); #1;
      if (got_ack) begin
        draw_adr  = 22'h000500 + 22'(acks);
        draw_data = 16'h1000 + 16'(acks);
      end
      if (acks == 1 && !disp_req && done_c < 0) begin
        disp_adr = 22'h000080; disp_len = 9'd2; disp_req = 1'b1;
      end
      if (done_c >= 0) disp_req = 1'b0;
      if (resumed >= 2) draw_req = 1'b0;
    end
    draw_req = 1'b0;
    chk("quota_acks_before_disp", 64'(pre), 64'(4));
    chk("quota_disp_reads", 64'(reads), 64'(2));
    chk("quota_draws_resumed", 64'(resumed), 64'(2));

    // Simultaneous requests: display served first
    @(posedge clk); #1;
    disp_adr = 22'h000040; disp_len = 9'd2; disp_req = 1'b1;
    draw_adr = 22'h000600; draw_data = 16'hBEEF; draw_req = 1'b1;
    done_c = -1; ack_c = -1; reads = 0; first_seen = 1'b0;
    for (int c = 0; c < 60 && ack_c < 0; c++) begin
      @(negedge clk);
      if (mem_req && mem_ack) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          chk("tie_first_is_read", 64'(mem_we), 64'(1'b0));
        end
        if (!mem_we) reads++;
      end
      if (disp_done) done_c = c;
      if (draw_ack) begin
        ack_c = c;
        chk("tie_wr_cmd", 64'({mem_we, mem_adr, mem_wdata}), 64'({1'b1, 22'h000600, 16'hBEEF}));
      end
      @(posedge clk); #1;
      if (done_c >= 0) disp_req = 1'b0;
      if (ack_c >= 0) draw_req = 1'b0;
    end
    disp_req = 1'b0; draw_req = 1'b0;
    chk("tie_reads", 64'(reads), 64'(2));
    chk("tie_ack_after_done", 64'(ack_c), 64'(done_c + 2));

    // Reset after 2 of 8 reads issued
    @(posedge clk); #1;
    disp_adr = 22'h000200; disp_len = 9'd8; disp_req = 1'b1; n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (mem_req && mem_ack) n++;
      @(posedge clk); #1;
    end
    p_reset_n = 1'b0; ack_en = 1'b0; disp_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_outputs", all_outs(), 64'h0);
    @(posedge clk); #1;
    p_reset_n = 1'b1; ack_en = 1'b1;
    late = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_rvalid) begin
        late++;
        chk("rst_late_rvalid", 64'({disp_rvalid, disp_rdata}), 64'h0);
      end
      chk("rst_idle_req", 64'(mem_req), 64'(1'b0));
      @(posedge clk); #1;
    end
    run_disp(22'h000300, 9'd3, 22'h000302, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
